ps2_scancode_decoder: RTL
=========================

// Module: ps2_scancode_decoder
// PURPOSE
//  Consumes the byte stream from the PS/2 data-in stage (received_data/received_data_en)
//  and turns Set-2 scan-code sequences into key events {extended, released, code}.
//  Strips E0/F0 prefixes, collapses the 8-byte Pause sequence and diverts device response
//  bytes to a control strobe. Buffers key events in a FWFT FIFO for the host logic.
// PARAMETERS
//  FIFO_DEPTH      8       key-event FIFO entries; power of 2, >=2
//  TIMEOUT_CYCLES  150000  clk cycles allowed between bytes of one sequence (3 ms @50 MHz)
// PORTS
//  clk            in   1  system clock
//  reset          in   1  asynchronous, active-high reset
//  received_data  in   8  byte from PS/2 data-in stage
//  received_data_en in 1  1-cycle strobe: received_data valid
//  key_rd         in   1  pop head of FIFO (ignored when key_empty)
//  overflow_clr   in   1  clears key_overflow
//  key_code       out  8  head entry code (FWFT, valid when !key_empty)
//  key_extended   out  1  head entry had E0 prefix
//  key_released   out  1  head entry had F0 prefix
//  key_empty      out  1  FIFO empty
//  key_full       out  1  FIFO full
//  key_overflow   out  1  sticky: event dropped because FIFO full
//  ctrl_byte      out  8  last device response byte
//  ctrl_byte_en   out  1  1-cycle strobe with ctrl_byte
//  seq_error      out  1  1-cycle strobe: malformed sequence or timeout
// BEHAVIOUR
//  Reset (async): state=S_IDLE, flags ext/rel=0, FIFO empty (key_empty=1, key_full=0),
//   key_code/ext/rel=0, key_overflow=0, ctrl_byte=8'h00, strobes 0, timeout/skip counters 0.
//  All decoding on the clk edge where received_data_en=1; no byte is lost while decoding.
//  S_IDLE: E0 -> ext=1, S_PREFIX; F0 -> rel=1, S_PREFIX; E1 -> skip_cnt=7, S_PAUSE;
//   AA/FA/FE/EE/00/FF -> ctrl_byte<=byte, ctrl_byte_en=1 next cycle, stay; else push
//   {ext=0,rel=0,code=byte}.
//  S_PREFIX: E0 with ext=0 and rel=0 impossible; E0 with ext=1 or rel=1 -> seq_error,
//   flags<= {ext=1,rel=0}; F0 with rel=0 -> rel=1; F0 with rel=1 -> seq_error, flags<=
//   {ext=0,rel=1}; any other byte (incl. control values) -> push {ext,rel,byte}, flags
//   cleared, S_IDLE. Valid orders: E0 xx, F0 xx, E0 F0 xx.
//  S_PAUSE: each byte decrements skip_cnt, contents ignored; on byte with skip_cnt==1
//   push {ext=0,rel=0,code=8'hE1}, S_IDLE. No release event for Pause.
//  Timeout: in S_PREFIX/S_PAUSE counter increments every cycle without received_data_en,
//   clears on each byte; reaching TIMEOUT_CYCLES-1 -> seq_error pulse, flags cleared,
//   S_IDLE, nothing pushed. Counter held at 0 in S_IDLE.
//  seq_error and ctrl_byte_en assert exactly one cycle, the cycle after the causing edge.
//  FIFO: entry {ext,rel,code} 10 bits; write on decode edge; key_empty falls the cycle
//   after received_data_en (1-cycle latency). Outputs show head combinationally from RAM/
//   registers, no extra read latency. key_rd with !key_empty pops on clk edge.
//  Simultaneous push+pop: non-empty -> both occur, count unchanged; full -> pop then push
//   succeeds, no overflow; empty -> pop ignored, push occurs.
//  Push when full without pop: event dropped, key_overflow<=1, FIFO contents unchanged.
//  key_overflow clears on overflow_clr; same-cycle new overflow wins (stays 1).
//  Pointers wrap modulo FIFO_DEPTH with extra MSB for full/empty distinction.
//  Reset mid-sequence or mid-pause: all state discarded, next byte decoded from S_IDLE.
// TESTING
//  1 Bytes 1C ; F0 1C -> two entries {0,0,1C},{0,1,1C}; key_empty low 1 cycle after 1st en.
//  2 E0 75 ; E0 F0 75 -> {1,0,75},{1,1,75}; E1 14 77 E1 F0 14 F0 77 -> single {0,0,E1}.
//  3 Byte AA in idle -> ctrl_byte=AA, ctrl_byte_en 1 cycle, FIFO stays empty; F0 then
//    no byte for TIMEOUT_CYCLES -> seq_error pulse, next 1C gives {0,0,1C}.
//  4 9 make codes without key_rd (depth 8) -> key_full=1, 9th dropped, key_overflow=1;
//    pop all -> codes in order, 1st..8th; overflow_clr -> key_overflow=0.
//  5 FIFO full, received_data_en and key_rd same cycle -> count stays 8, no overflow,
//    new code at tail; F0 F0 1C -> seq_error once, then {0,1,1C}.
//  6 Assert reset after E0 (mid-sequence) and with 3 entries queued -> key_empty=1
//    immediately; next 75 -> {0,0,75}.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_decoder
// Purpose  : Turns the PS/2 Set-2 byte stream into key events
//            {extended, released, code}. E0/F0 prefixes are stripped, the
//            8-byte Pause sequence collapses to a single E1 event, and device
//            response bytes are diverted to a control strobe. Key events are
//            buffered in a first-word-fall-through FIFO.
// Ports    : clk, reset (async, active-high)
//            received_data[7:0], received_data_en : byte stream in
//            key_rd, overflow_clr                 : host FIFO controls
//            key_code[7:0], key_extended, key_released,
//            key_empty, key_full, key_overflow    : FIFO head and status
//            ctrl_byte[7:0], ctrl_byte_en         : device response byte
//            seq_error                            : malformed seq / timeout
// Revision : 1.0 - initial release
// ============================================================================
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 150000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       key_rd,
  input  logic       overflow_clr,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_empty,
  output logic       key_full,
  output logic       key_overflow,
  output logic [7:0] ctrl_byte,
  output logic       ctrl_byte_en,
  output logic       seq_error
);

  localparam int              c_AW       = $clog2(FIFO_DEPTH);
  localparam int              c_TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TW-1:0] c_TMO_ONE  = c_TW'(1);
  localparam logic [c_AW:0]   c_PTR_ONE  = (c_AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PREFIX = 2'd1,
    S_PAUSE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ext_q, ext_d, rel_q, rel_d;
  logic [2:0]      skip_q, skip_d;
  logic [c_TW-1:0] tmo_q, tmo_d;
  logic [7:0]      ctrl_byte_q, ctrl_byte_d;
  logic            ctrl_en_q, ctrl_en_d;
  logic            seq_err_q, seq_err_d;

  logic            w_push;
  logic [9:0]      w_push_word;

  // --------------------------------------------------------------------------
  // Decoder
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    skip_d      = skip_q;
    tmo_d       = tmo_q;
    ctrl_byte_d = ctrl_byte_q;
    ctrl_en_d   = 1'b0;
    seq_err_d   = 1'b0;
    w_push      = 1'b0;
    w_push_word = {ext_q, rel_q, received_data};

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (received_data_en) begin
          case (received_data)
            8'hE0: begin ext_d = 1'b1; rel_d = 1'b0; state_d = S_PREFIX; end
            8'hF0: begin ext_d = 1'b0; rel_d = 1'b1; state_d = S_PREFIX; end
            8'hE1: begin skip_d = 3'd7; state_d = S_PAUSE; end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
              ctrl_byte_d = received_data;
              ctrl_en_d   = 1'b1;
            end
            default: begin
              w_push      = 1'b1;
              w_push_word = {2'b00, received_data};
            end
          endcase
        end
      end

      S_PREFIX: begin
        if (received_data_en) begin
          tmo_d = '0;
          case (received_data)
            // A fresh E0 restarts the sequence as an extended prefix.
            8'hE0: begin
              if (ext_q || rel_q) seq_err_d = 1'b1;
              ext_d = 1'b1;
              rel_d = 1'b0;
            end
            // A repeated F0 restarts the sequence as a plain release.
            8'hF0: begin
              if (rel_q) begin
                seq_err_d = 1'b1;
                ext_d     = 1'b0;
              end
              rel_d = 1'b1;
            end
            default: begin
              w_push  = 1'b1;
              ext_d   = 1'b0;
              rel_d   = 1'b0;
              state_d = S_IDLE;
            end
          endcase
        end else if (tmo_q == c_TMO_LAST) begin
          seq_err_d = 1'b1;
          ext_d     = 1'b0;
          rel_d     = 1'b0;
          tmo_d     = '0;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + c_TMO_ONE;
        end
      end

      S_PAUSE: begin
        if (received_data_en) begin
          tmo_d  = '0;
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            w_push      = 1'b1;
            w_push_word = {2'b00, 8'hE1};
            state_d     = S_IDLE;
          end
        end else if (tmo_q == c_TMO_LAST) begin
          seq_err_d = 1'b1;
          ext_d     = 1'b0;
          rel_d     = 1'b0;
          skip_d    = '0;
          tmo_d     = '0;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + c_TMO_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      skip_q      <= '0;
      tmo_q       <= '0;
      ctrl_byte_q <= 8'h00;
      ctrl_en_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      skip_q      <= skip_d;
      tmo_q       <= tmo_d;
      ctrl_byte_q <= ctrl_byte_d;
      ctrl_en_q   <= ctrl_en_d;
      seq_err_q   <= seq_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Key-event FIFO (pointers carry an extra wrap bit)
  // --------------------------------------------------------------------------
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [c_AW:0] wr_q, rd_q;
  logic          ovf_q;
  logic          w_empty, w_full, w_pop, w_wr, w_ovf;
  logic [9:0]    w_head;

  assign w_empty = (wr_q == rd_q);
  assign w_full  = (wr_q[c_AW] != rd_q[c_AW]) && (wr_q[c_AW-1:0] == rd_q[c_AW-1:0]);
  assign w_pop   = key_rd && !w_empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_ovf   = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_q[c_AW-1:0]] <= w_push_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (w_wr)  wr_q <= wr_q + c_PTR_ONE;
      if (w_pop) rd_q <= rd_q + c_PTR_ONE;
      if (w_ovf)             ovf_q <= 1'b1;
      else if (overflow_clr) ovf_q <= 1'b0;
    end
  end

  // Head is gated so the outputs read zero whenever the FIFO is empty.
  assign w_head       = w_empty ? 10'd0 : mem_q[rd_q[c_AW-1:0]];
  assign key_code     = w_head[7:0];
  assign key_released = w_head[8];
  assign key_extended = w_head[9];
  assign key_empty    = w_empty;
  assign key_full     = w_full;
  assign key_overflow = ovf_q;
  assign ctrl_byte    = ctrl_byte_q;
  assign ctrl_byte_en = ctrl_en_q;
  assign seq_error    = seq_err_q;

endmodule
`default_nettype wire
